// File: rtl/lna_duty_seq.sv
// lna_duty_seq: LNA power-down/settle/listen duty-cycle sequencer behind a small CPU register port.
// Optional irq output and listen-window counter are built when LNA_DUTY_SEQ_IRQ_EN is defined.
module lna_duty_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [2:0]        address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wstrb,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              pd,
    output logic [2:0]        mode,
    output logic              rx_en
`ifdef LNA_DUTY_SEQ_IRQ_EN
    ,
    output logic              irq
`endif
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_ON = 2'd2, S_OFF = 2'd3} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, settle_q, settle_d, on_q, on_d, off_q, off_d;
    logic [2:0]        mode_reg_q, mode_reg_d, mode_q, mode_d, ctrl_rd;
    logic              en_q, en_d, oneshot_q, oneshot_d, done_q, done_d;
    logic              pd_q, pd_d, rx_en_q, rx_en_d, ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
    logic              wr, cnt_last, on_exit, set_done, unused_wdata;
`ifdef LNA_DUTY_SEQ_IRQ_EN
    logic              irq_mask_q, irq_mask_d, irq_q, irq_d;
    logic [15:0]       win_q, win_d;
    assign ctrl_rd = {irq_mask_q, oneshot_q, en_q};
    assign irq     = irq_q;
`else
    assign ctrl_rd = {1'b0, oneshot_q, en_q};
`endif
    assign unused_wdata = ^wdata;
    assign wr       = valid & wstrb;
    assign cnt_last = cnt_q <= CNT_W'(1);
    assign ready    = ready_q;
    assign rdata    = rdata_q;
    assign pd       = pd_q;
    assign mode     = mode_q;
    assign rx_en    = rx_en_q;

    always_comb begin
        rd_val = '0;
        case (address)
            3'd0: rd_val[2:0] = ctrl_rd;
            3'd1: rd_val[2:0] = mode_reg_q;
            3'd2: rd_val[CNT_W-1:0] = settle_q;
            3'd3: rd_val[CNT_W-1:0] = on_q;
            3'd4: rd_val[CNT_W-1:0] = off_q;
            3'd5: rd_val[2:0] = {done_q, state_q};
`ifdef LNA_DUTY_SEQ_IRQ_EN
            3'd6: rd_val[15:0] = win_q;
`endif
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        on_d       = on_q;
        off_d      = off_q;
        mode_reg_d = mode_reg_q;
        mode_d     = mode_q;
        en_d       = en_q;
        oneshot_d  = oneshot_q;
        done_d     = done_q;
        on_exit    = 1'b0;
        set_done   = 1'b0;
        ready_d    = valid;
        rdata_d    = (valid && !wstrb) ? rd_val : '0;
`ifdef LNA_DUTY_SEQ_IRQ_EN
        irq_mask_d = irq_mask_q;
`endif
        // EN is sampled from its register, so a CPU clear stops the sequence one edge after the write
        if (!en_q) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SETTLE;
                    cnt_d   = settle_q;
                    mode_d  = mode_reg_q;
                end
                S_SETTLE: begin
                    state_d = cnt_last ? S_ON : S_SETTLE;
                    cnt_d   = cnt_last ? on_q : cnt_q - CNT_W'(1);
                end
                S_ON: begin
                    on_exit  = cnt_last;
                    set_done = cnt_last & oneshot_q;
                    state_d  = !cnt_last ? S_ON : (oneshot_q ? S_IDLE : S_OFF);
                    cnt_d    = cnt_last ? off_q : cnt_q - CNT_W'(1);
                end
                default: begin
                    state_d = cnt_last ? S_SETTLE : S_OFF;
                    cnt_d   = cnt_last ? settle_q : cnt_q - CNT_W'(1);
                    mode_d  = cnt_last ? mode_reg_q : mode_q;
                end
            endcase
        end
        if (wr) begin
            case (address)
                3'd0: begin
                    en_d      = wdata[0];
                    oneshot_d = wdata[1];
`ifdef LNA_DUTY_SEQ_IRQ_EN
                    irq_mask_d = wdata[2];
`endif
                end
                3'd1: mode_reg_d = wdata[2:0];
                3'd2: settle_d = wdata[CNT_W-1:0];
                3'd3: on_d = wdata[CNT_W-1:0];
                3'd4: off_d = wdata[CNT_W-1:0];
                3'd5: done_d = 1'b0;
                default: done_d = done_q;
            endcase
        end
        // A simultaneous CPU write to CTRL takes priority over the one-shot self-clear
        if (set_done && !(wr && address == 3'd0)) begin
            en_d      = 1'b0;
            oneshot_d = 1'b0;
        end
        if (set_done) done_d = 1'b1;
        pd_d    = state_d == S_IDLE || state_d == S_OFF;
        rx_en_d = state_d == S_ON;
`ifdef LNA_DUTY_SEQ_IRQ_EN
        win_d = (wr && address == 3'd6) ? 16'd0 : win_q + 16'(on_exit);
        irq_d = on_exit & ~irq_mask_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            settle_q   <= '0;
            on_q       <= '0;
            off_q      <= '0;
            mode_reg_q <= '0;
            mode_q     <= '0;
            en_q       <= 1'b0;
            oneshot_q  <= 1'b0;
            done_q     <= 1'b0;
            pd_q       <= 1'b1;
            rx_en_q    <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
`ifdef LNA_DUTY_SEQ_IRQ_EN
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
            win_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            on_q       <= on_d;
            off_q      <= off_d;
            mode_reg_q <= mode_reg_d;
            mode_q     <= mode_d;
            en_q       <= en_d;
            oneshot_q  <= oneshot_d;
            done_q     <= done_d;
            pd_q       <= pd_d;
            rx_en_q    <= rx_en_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
`ifdef LNA_DUTY_SEQ_IRQ_EN
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
            win_q      <= win_d;
`endif
        end
    end
endmodule

// File: tb/tb_lna_duty_seq.sv
// tb_lna_duty_seq: directed bench for lna_duty_seq; register table plus duty-cycle timing sequences.
module tb_lna_duty_seq;
    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, wstrb = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] wdata = '0;
    logic        ready, pd, rx_en;
    logic [31:0] rdata, rd;
    logic [2:0]  mode;
    int          total = 0, bad = 0, cyc = 0, c0 = 0, k, p, nirq;
`ifdef LNA_DUTY_SEQ_IRQ_EN
    logic irq;
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    lna_duty_seq dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .rdata(rdata), .pd(pd), .mode(mode), .rx_en(rx_en)
`ifdef LNA_DUTY_SEQ_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int kk, input logic epd, input logic erx, input logic [2:0] em);
        chk($sformatf("%s k=%0d {pd,rx_en,mode}", nm, kk), {pd, rx_en, mode}, {epd, erx, em});
    endtask

    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        valid = 1'b1; wstrb = w; address = a; wdata = d;
        @(negedge clk);
        chk($sformatf("ready a=%0d", a), ready, 1);
        r = rdata;
        valid = 1'b0; wstrb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) vt.push_back('{1'b0, 3'(i), 32'h0, 32'h0});
        vt.push_back('{1'b1, 3'd1, 32'hFFFF_FFFD, 32'h0}); vt.push_back('{1'b0, 3'd1, 32'h0, 32'h5});
        vt.push_back('{1'b1, 3'd2, 32'hABCD_1234, 32'h0}); vt.push_back('{1'b0, 3'd2, 32'h0, 32'h1234});
        vt.push_back('{1'b1, 3'd2, 32'h4, 32'h0});         vt.push_back('{1'b0, 3'd2, 32'h0, 32'h4});
        vt.push_back('{1'b1, 3'd3, 32'hA, 32'h0});         vt.push_back('{1'b0, 3'd3, 32'h0, 32'hA});
        vt.push_back('{1'b1, 3'd4, 32'h6, 32'h0});         vt.push_back('{1'b0, 3'd4, 32'h0, 32'h6});
        vt.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0}); vt.push_back('{1'b0, 3'd7, 32'h0, 32'h0});
        vt.push_back('{1'b1, 3'd5, 32'hFF, 32'h0});        vt.push_back('{1'b0, 3'd5, 32'h0, 32'h0});
        vt.push_back('{1'b1, 3'd6, 32'h1234, 32'h0});      vt.push_back('{1'b0, 3'd6, 32'h0, 32'h0});
        vt.push_back('{1'b1, 3'd0, 32'h6, 32'h0});         vt.push_back('{1'b0, 3'd0, 32'h0, HAS_IRQ ? 32'h6 : 32'h2});
        vt.push_back('{1'b1, 3'd0, 32'h0, 32'h0});         vt.push_back('{1'b0, 3'd0, 32'h0, 32'h0});

        // reset values
        repeat (2) @(negedge clk);
        chk("reset {pd,rx_en,mode}", {pd, rx_en, mode}, 5'b10000);
        chk("reset ready", ready, 0);
        chk("reset rdata", rdata, 0);
        rst = 1'b0;

        foreach (vt[i]) begin
            bus(vt[i].w, vt[i].a, vt[i].d, rd);
            if (!vt[i].w) chk($sformatf("vec%0d rdata a=%0d", i, vt[i].a), rd, vt[i].e);
            @(negedge clk);
            chk($sformatf("vec%0d ready drop", i), ready, 0);
        end

        // valid held high: one access per cycle, ready stays 1
        @(negedge clk);
        valid = 1'b1; wstrb = 1'b0; address = 3'd1;
        @(negedge clk);
        chk("b2b ready0", ready, 1); chk("b2b rdata0", rdata, 5);
        address = 3'd4;
        @(negedge clk);
        chk("b2b ready1", ready, 1); chk("b2b rdata1", rdata, 6);
        valid = 1'b0;
        @(negedge clk);
        chk("b2b ready end", ready, 0);

        // free-running duty cycle: settle 4, on 10, off 6, period 20
        bus(1'b1, 3'd0, 32'h1, rd);
        c0 = cyc;
        chk_out("duty", 0, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            k = cyc - c0; p = (k - 1) % 20;
            chk_out("duty", k, p >= 14, p >= 4 && p < 14, 3'd5);
        end
        // MODE written during ON applies at the next SETTLE entry (k=61)
        bus(1'b1, 3'd1, 32'h2, rd);
        while (cyc - c0 < 70) begin
            @(negedge clk);
            k = cyc - c0; p = (k - 1) % 20;
            chk_out("mchg", k, p >= 14, p >= 4 && p < 14, k >= 61 ? 3'd2 : 3'd5);
        end
        // EN cleared mid-ON
        bus(1'b1, 3'd0, 32'h0, rd);
        @(negedge clk);
        chk("enclr {pd,rx_en}", {pd, rx_en}, 2'b10);
        bus(1'b0, 3'd5, 32'h0, rd);
        chk("enclr status", rd, 0);

        // one-shot window: settle 2, on 3
        bus(1'b1, 3'd2, 32'h2, rd);
        bus(1'b1, 3'd3, 32'h3, rd);
        bus(1'b1, 3'd0, 32'h3, rd);
        c0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            k = cyc - c0;
            chk_out("oneshot", k, !(k >= 1 && k <= 5), k >= 3 && k <= 5, 3'd2);
        end
        bus(1'b0, 3'd0, 32'h0, rd); chk("oneshot ctrl", rd, 0);
        bus(1'b0, 3'd5, 32'h0, rd); chk("oneshot status", rd, 4);
        bus(1'b1, 3'd5, 32'h0, rd);
        bus(1'b0, 3'd5, 32'h0, rd); chk("oneshot status clr", rd, 0);

        // asynchronous reset mid-SETTLE
        bus(1'b1, 3'd2, 32'h8, rd);
        bus(1'b1, 3'd0, 32'h1, rd);
        bus(1'b0, 3'd5, 32'h0, rd); chk("rst pre status", rd, 1);
        @(negedge clk);
        chk("rst pre {pd,rx_en,mode}", {pd, rx_en, mode}, 5'b00010);
        #2 rst = 1'b1;
        #1 chk("rst async {pd,rx_en,mode}", {pd, rx_en, mode}, 5'b10000);
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, 3'd5, 32'h0, rd); chk("rst status", rd, 0);
        bus(1'b0, 3'd0, 32'h0, rd); chk("rst ctrl", rd, 0);
        bus(1'b0, 3'd2, 32'h0, rd); chk("rst settle", rd, 0);
        bus(1'b0, 3'd1, 32'h0, rd); chk("rst mode", rd, 0);

        // zero timers: each state one cycle, three windows then stop
        nirq = 0;
        bus(1'b1, 3'd0, 32'h1, rd);
        c0 = cyc;
        for (int i = 1; i <= 10; i++) begin
            if (i == 8) bus(1'b1, 3'd0, 32'h0, rd);
            else @(negedge clk);
            k = cyc - c0; p = (k - 1) % 3;
            if (k >= 9) chk_out("zero", k, 1'b1, 1'b0, 3'd0);
            else chk_out("zero", k, p == 2, p == 1, 3'd0);
`ifdef LNA_DUTY_SEQ_IRQ_EN
            chk($sformatf("zero irq k=%0d", k), irq, k <= 9 && p == 2);
            nirq += int'(irq);
`endif
            if (i == 8) i = 9;
        end
`ifdef LNA_DUTY_SEQ_IRQ_EN
        chk("zero irq pulses", nirq, 3);
`endif
        bus(1'b0, 3'd6, 32'h0, rd); chk("zero wincnt", rd, HAS_IRQ ? 32'd3 : 32'd0);

        // IRQ_MASK suppresses irq while the window count keeps going
        bus(1'b1, 3'd0, 32'h5, rd);
        c0 = cyc;
        for (int i = 1; i <= 10; i++) begin
            if (i == 8) bus(1'b1, 3'd0, 32'h0, rd);
            else @(negedge clk);
            k = cyc - c0; p = (k - 1) % 3;
            if (k >= 9) chk_out("mask", k, 1'b1, 1'b0, 3'd0);
            else chk_out("mask", k, p == 2, p == 1, 3'd0);
`ifdef LNA_DUTY_SEQ_IRQ_EN
            chk($sformatf("mask irq k=%0d", k), irq, 0);
`endif
            if (i == 8) i = 9;
        end
        bus(1'b0, 3'd6, 32'h0, rd); chk("mask wincnt", rd, HAS_IRQ ? 32'd6 : 32'd0);
        bus(1'b1, 3'd6, 32'h0, rd);
        bus(1'b0, 3'd6, 32'h0, rd); chk("wincnt clr", rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
